// File: rtl/ncl_stage_sequencer_pkg.sv
// ncl_seq_pkg: shared types and helpers for the NCL stage sequencer.
//   state_e        sequencer FSM states
//   rail_complete  one dual-rail pair carries DATA (exactly one rail high)
//   rail_illegal   one dual-rail pair has both rails high
//   rr_pick        round-robin winner search starting at a pointer
package ncl_seq_pkg;

  localparam int unsigned MAX_REQ = 4;

  typedef enum logic [2:0] {
    RST_HOLD,
    IDLE,
    DATA,
    NULL,
    RESP,
    RECOVER
  } state_e;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } pick_t;

  function automatic logic rail_complete(input logic y1, input logic y0);
    return y1 ^ y0;
  endfunction

  function automatic logic rail_illegal(input logic y1, input logic y0);
    return y1 & y0;
  endfunction

  // First asserted request at or after ptr, wrapping modulo nreq.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [1:0]         ptr,
                                    input int unsigned        nreq);
    pick_t       p;
    int unsigned idx;
    logic [1:0]  idx2;
    p = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx  = (int'(ptr) + k) % nreq;
      idx2 = idx[1:0];
      if (k < nreq && !p.found && valid[idx2]) begin
        p.found = 1'b1;
        p.idx   = idx2;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/ncl_stage_sequencer_sync2.sv
// ncl_sync2: two-flop synchronizer for signals arriving from the NCL stage.
//   clk, rst : sole clock, synchronous active-high reset (clears to 0)
//   d_i      : asynchronous input bus
//   q_o      : synchronized output bus
module ncl_sync2 #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ncl_stage_sequencer.sv
// ncl_stage_sequencer: shares one NCL threshold-gate stage among NREQ
// synchronous requesters. Grants round-robin, drives the operand as a DATA
// wavefront, waits for completion, returns the stage to NULL and presents
// the single-rail result.
//   req_valid/req_data/req_ready        requester side (one-hot grant pulse)
//   stage_d1/stage_d0/stage_rsb         dual-rail operand and gate reset
//   stage_ko/stage_y1/stage_y0          asynchronous completion and result
//   rsp_valid/rsp_ready/rsp_data/rsp_id/rsp_err   response side
//   busy                                high in every state except IDLE
module ncl_stage_sequencer
  import ncl_seq_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned RWIDTH  = 1,
  parameter int unsigned TIMEOUT = 31,
  parameter int unsigned RST_CYC = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [WIDTH-1:0]        stage_d1,
  output logic [WIDTH-1:0]        stage_d0,
  output logic                    stage_rsb,
  input  logic                    stage_ko,
  input  logic [RWIDTH-1:0]       stage_y1,
  input  logic [RWIDTH-1:0]       stage_y0,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [RWIDTH-1:0]       rsp_data,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned SW  = 2 * RWIDTH + 1;

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0]  op_q, op_d;
  logic [IDW-1:0]    id_d;
  logic [RWIDTH-1:0] data_d;
  logic              err_d;
  logic [NREQ-1:0]   gnt_d;

  logic [SW-1:0]     sync_out;
  logic              ko_s;
  logic [RWIDTH-1:0] y1_s, y0_s;
  logic              all_cmp, any_ill, all_null;

  pick_t             pick;
  logic [IDW-1:0]    win;
  logic [NREQ-1:0]   gnt_v;
  logic [WIDTH-1:0]  op_sel;

  ncl_sync2 #(.W(SW)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i ({stage_ko, stage_y1, stage_y0}),
    .q_o (sync_out)
  );

  assign ko_s     = sync_out[SW-1];
  assign y1_s     = sync_out[2*RWIDTH-1:RWIDTH];
  assign y0_s     = sync_out[RWIDTH-1:0];
  assign all_null = ~|{y1_s, y0_s};

  always_comb begin
    all_cmp = 1'b1;
    any_ill = 1'b0;
    for (int unsigned i = 0; i < RWIDTH; i++) begin
      all_cmp &= rail_complete(y1_s[i], y0_s[i]);
      any_ill |= rail_illegal(y1_s[i], y0_s[i]);
    end
  end

  always_comb begin
    pick   = rr_pick(MAX_REQ'(req_valid), 2'(ptr_q), NREQ);
    win    = IDW'(pick.idx);
    gnt_v  = '0;
    op_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win) begin
        gnt_v[i] = 1'b1;
        op_sel   = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    ptr_d   = ptr_q;
    op_d    = op_q;
    id_d    = rsp_id;
    data_d  = rsp_data;
    err_d   = rsp_err;
    gnt_d   = '0;
    case (state_q)
      RST_HOLD: begin
        if (cnt_q == 5'(RST_CYC - 1)) state_d = IDLE;
        else                          cnt_d   = cnt_q + 5'd1;
      end
      IDLE: begin
        if (pick.found) begin
          state_d = DATA;
          gnt_d   = gnt_v;
          op_d    = op_sel;
          id_d    = win;
          ptr_d   = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
          data_d  = '0;
          err_d   = 1'b0;
        end
      end
      DATA: begin
        if (any_ill) begin
          state_d = RECOVER;
          err_d   = 1'b1;
          data_d  = '0;
        end else if (!ko_s && all_cmp) begin
          state_d = NULL;
          data_d  = y1_s;
        end else if (cnt_q == 5'(TIMEOUT - 1)) begin
          state_d = RECOVER;
          err_d   = 1'b1;
          data_d  = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      NULL: begin
        if (ko_s && all_null) begin
          state_d = RESP;
        end else if (cnt_q == 5'(TIMEOUT - 1)) begin
          state_d = RECOVER;
          err_d   = 1'b1;
          data_d  = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) state_d = IDLE;
      end
      RECOVER: begin
        if (cnt_q == 5'(RST_CYC - 1)) state_d = RESP;
        else                          cnt_d   = cnt_q + 5'd1;
      end
      default: state_d = RST_HOLD;
    endcase
  end

  // Outputs are registered from the next state so rails, grant and
  // gate reset change in the same cycle the FSM enters its new state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RST_HOLD;
      cnt_q     <= '0;
      ptr_q     <= '0;
      op_q      <= '0;
      req_ready <= '0;
      stage_d1  <= '0;
      stage_d0  <= '0;
      stage_rsb <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      op_q      <= op_d;
      req_ready <= gnt_d;
      stage_d1  <= (state_d == DATA) ? op_d  : '0;
      stage_d0  <= (state_d == DATA) ? ~op_d : '0;
      stage_rsb <= !((state_d == RST_HOLD) || (state_d == RECOVER));
      rsp_valid <= (state_d == RESP);
      rsp_data  <= data_d;
      rsp_id    <= id_d;
      rsp_err   <= err_d;
      busy      <= (state_d != IDLE);
    end
  end

endmodule
